// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store port with LATENCY wait states.
// Optional DMEM_ACCESS_CHECK_EN flags misaligned / out-of-range addresses via rsp_err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rerr_q, rerr_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept, enter_resp, mem_we, req_err;
  logic            cur_we, cur_err;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic [3:0]      cur_wstrb;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_ACCESS_CHECK_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH_WORDS));
`else
  assign req_err = 1'b0;
`endif

  assign accept    = req_valid && (state_q == IDLE);
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

  // With zero wait states the access happens on the accept edge, so the
  // live request is used instead of the not-yet-latched copy.
  always_comb begin
    if (accept) begin
      cur_we    = req_we;
      cur_idx   = req_addr[AW+1:2];
      cur_wdata = req_wdata;
      cur_wstrb = req_wstrb;
      cur_err   = req_err;
    end else begin
      cur_we    = we_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_wstrb = wstrb_q;
      cur_err   = err_q;
    end
  end

  assign enter_resp = (accept && (LATENCY == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd1));
  // reset in the same cycle must suppress the commit: aborted stores never land
  assign mem_we = enter_resp && cur_we && !cur_err && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          err_d   = req_err;
          if (LATENCY == 0) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          rerr_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = (cur_we || cur_err) ? 32'd0 : mem[cur_idx];
      rerr_d  = cur_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_wstrb[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder (LATENCY=2 and LATENCY=0 instances).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b1;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic [3:0]  req_wstrb0 = '0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mem_m [256];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0));

  function automatic logic exp_err_of(input logic [31:0] a);
`ifdef DMEM_ACCESS_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'd1024);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one request on dut, report cycles from accept to rsp_valid and response fields.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, output int lat, output logic [31:0] rd,
                      output logic er);
    int g;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    n_cmp++;
    if (g >= 50) begin n_bad++; $display("FAIL accept_timeout: req_ready stuck low"); end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (!rsp_valid) begin
        n_cmp++;
        if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_rsp_zero: rdata=%h err=%b required 0/0", rsp_rdata, rsp_err);
        end
      end
    end while (!rsp_valid && lat < 50);
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: valid=%b rdata=%h err=%b required 0/0/0",
                        rsp_valid, rsp_rdata, rsp_err);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: req_ready=%b/%b required 1/1", req_ready, req_ready0);
    end
  endtask

  task automatic test_directed;
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    n_cmp++;
    if (lat != 3 || rd !== 32'd0) begin
      n_bad++; $display("FAIL store_0x10: lat=%0d rdata=%h required 3/0", lat, rd);
    end
    xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (lat != 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_bad++; $display("FAIL load_0x10: lat=%0d rdata=%h err=%b required 3/deadbeef/0", lat, rd, er);
    end
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, er);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'h2, lat, rd, er);
    xact(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'h1122CC44) begin
      n_bad++; $display("FAIL partial_strobe: rdata=%h required 1122cc44", rd);
    end
    xact(1'b1, 32'h24, 32'h55667788, 4'hF, lat, rd, er);
    xact(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, lat, rd, er);
    xact(1'b0, 32'h24, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'h55667788) begin
      n_bad++; $display("FAIL zero_strobe: rdata=%h required 55667788", rd);
    end
    xact(1'b1, 32'h0, 32'h0BADF00D, 4'hF, lat, rd, er);
    xact(1'b0, 32'h402, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
`ifdef DMEM_ACCESS_CHECK_EN
    if (rd !== 32'd0 || er !== 1'b1 || lat != 3) begin
      n_bad++; $display("FAIL load_0x402: rdata=%h err=%b lat=%0d required 0/1/3", rd, er, lat);
    end
`else
    if (rd !== 32'h0BADF00D || er !== 1'b0 || lat != 3) begin
      n_bad++; $display("FAIL load_0x402: rdata=%h err=%b lat=%0d required 0badf00d/0/3", rd, er, lat);
    end
`endif
  endtask

  task automatic test_backpressure;
    int g; int lat; logic [31:0] rd; logic er;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (!rsp_valid && g < 50);
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hF; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
        n_bad++; $display("FAIL hold_resp[%0d]: valid=%b rdata=%h ready=%b required 1/deadbeef/0",
                          k, rsp_valid, rsp_rdata, req_ready);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL ignored_req: rdata=%h required deadbeef", rd);
    end
  endtask

  task automatic test_reset_abort;
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 32'h40, 32'h00000077, 4'hF, lat, rd, er);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h5; req_wstrb = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL abort_state: ready=%b valid=%b required 1/0", req_ready, rsp_valid);
    end
    repeat (4) @(negedge clk);
    xact(1'b0, 32'h40, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'h00000077) begin
      n_bad++; $display("FAIL abort_no_write: rdata=%h required 00000077", rd);
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd; logic er;
    logic we; logic [31:0] a, wd, exp_rd; logic [3:0] ws; logic exp_er; int idx;
    for (int i = 0; i < 256; i++) begin
      wd = $urandom;
      mem_m[i] = wd;
      xact(1'b1, 32'(i * 4), wd, 4'hF, lat, rd, er);
    end
    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? $urandom : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      wd = $urandom;
      ws = 4'($urandom);
      idx = int'(a[9:2]);
      exp_er = exp_err_of(a);
      exp_rd = (we || exp_er) ? 32'd0 : mem_m[idx];
      if (we && !exp_er)
        for (int b = 0; b < 4; b++) if (ws[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      xact(we, a, wd, ws, lat, rd, er);
      n_cmp++;
      if (lat != 3 || rd !== exp_rd || er !== exp_er) begin
        n_bad++; $display("FAIL random[%0d] we=%b addr=%h: lat=%0d rdata=%h err=%b required 3/%h/%b",
                          t, we, a, lat, rd, er, exp_rd, exp_er);
      end
    end
  endtask

  task automatic test_back_to_back_lat0;
    int g; logic exp_rr;
    @(negedge clk);
    req_we0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = 32'hCAFEF00D; req_wstrb0 = 4'hF; req_valid0 = 1'b1;
    g = 0;
    while (!req_ready0 && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1 req_we0 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_rr = (k % 2 == 0);
      n_cmp++;
      if (req_ready0 !== exp_rr || rsp_valid0 !== !exp_rr) begin
        n_bad++; $display("FAIL lat0_cycle[%0d]: ready=%b valid=%b required %b/%b",
                          k, req_ready0, rsp_valid0, exp_rr, !exp_rr);
      end
      if (!exp_rr) begin
        n_cmp++;
        if (rsp_rdata0 !== ((k == 1) ? 32'd0 : 32'hCAFEF00D)) begin
          n_bad++; $display("FAIL lat0_data[%0d]: rdata=%h", k, rsp_rdata0);
        end
      end
    end
    req_valid0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_abort;
    test_back_to_back_lat0;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of 2, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, wait-state cycles per access (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address (core ALU result).
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_wstrb  input  4  byte-lane write enables, bit n = bits 8n+7:8n.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  core accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores.
REQ-014 SHALL have port rsp_err  output  1  access error flag (see Configuration).

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-016 SHALL accept a request on a cycle with req_valid and req_ready both 1, latching we, addr, wdata, wstrb.
REQ-017 On accept, SHALL go to WAIT with a down-counter loaded to LATENCY, or directly to RESP when LATENCY = 0.
REQ-018 In WAIT, SHALL decrement the counter each cycle and enter RESP on the edge where the counter is 1.
REQ-019 rsp_valid SHALL first assert exactly LATENCY+1 cycles after the accept edge.
REQ-020 On the edge entering RESP, SHALL commit a store (only lanes with wstrb set) or capture load data into rsp_rdata.
REQ-021 In RESP, SHALL hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready = 1, then return to IDLE on that edge.
REQ-022 SHALL allow at most one outstanding request; req_valid ignored outside IDLE.
REQ-023 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; req_addr[1:0] ignored; upper bits wrap (without macro).
REQ-024 A load following a store to the same word SHALL return the post-store value.
REQ-025 Store response SHALL drive rsp_rdata = 0; wstrb = 0 store SHALL complete with memory unchanged.
REQ-026 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid = 0.

Reset
REQ-027 reset SHALL force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 at the next edge; req_ready 1 the cycle after.
REQ-028 reset asserted in WAIT SHALL abort the access; a store not yet committed SHALL never be written.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DMEM_ACCESS_CHECK_EN SHALL enable address checking.
REQ-031 With DMEM_ACCESS_CHECK_EN: req_addr[1:0] != 0 or req_addr >= 4*DEPTH_WORDS SHALL give rsp_err = 1, no write, rsp_rdata = 0, same latency.
REQ-032 Without DMEM_ACCESS_CHECK_EN: rsp_err SHALL be constant 0 and addressing SHALL follow REQ-023.

Verification (DEPTH_WORDS=256, LATENCY=2 unless stated)
REQ-033 Store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then load 0x10 -> load rsp_rdata 0xDEADBEEF, rsp_valid 3 cycles after each accept.
REQ-034 Word 0x20 holds 0x11223344; store wstrb 0x2, wdata 0xAABBCCDD; load 0x20 -> 0x1122CC44.
REQ-035 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0, second req_valid ignored.
REQ-036 Store 0x40 wdata 0x5, reset pulsed 1 cycle after accept, then load 0x40 -> previous content, no 0x5.
REQ-037 LATENCY=0: load accepted at cycle n -> rsp_valid at n+1; back-to-back accepts every 2 cycles with rsp_ready tied 1.
REQ-038 Load 0x402: with DMEM_ACCESS_CHECK_EN -> rsp_err 1, rsp_rdata 0; without -> rsp_err 0, data of word index 0.
